// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl
//   Sequencer for the load/compare/control inputs of one pwm_gen instance.
//   It ramps the duty (compare) from its current value to a target in fixed
//   steps. One step is taken every (cfg_hold_i + 1) PWM periods. A stop request
//   ramps the duty down to 0 and then disables the PWM. Compare only changes on
//   a PWM period boundary, so every period runs with one consistent duty.
//
//   Optional feature: define PWM_FADE_IRQ_EN to add a sticky interrupt
//   (irq_o / irq_ack_i). irq_o is set by done and cleared by irq_ack_i. If set
//   and ack happen in the same cycle, set wins.
//
// Ports
//   clk_i         clock, shared with pwm_gen
//   rst_ni        asynchronous active-low reset
//   cfg_load_i    PWM period value, latched only on a start from IDLE
//   cfg_target_i  target compare, sampled on every accepted start
//   cfg_step_i    compare increment per step (0 acts as 1)
//   cfg_hold_i    PWM periods per step minus 1
//   cmd_start_i   pulse: enable and ramp to target, or retarget
//   cmd_stop_i    pulse: ramp to 0, then disable (wins over cmd_start_i)
//   irq_ack_i     (PWM_FADE_IRQ_EN only) clears irq_o
//   irq_o         (PWM_FADE_IRQ_EN only) sticky done interrupt
//   load_o        to pwm_gen.load
//   compare_o     to pwm_gen.compare
//   control_o     to pwm_gen.control; bit0 = enable, all other bits 0
//   busy_o        high while ramping up/down (RAMP or FALL)
//   done_o        1-cycle pulse on reaching target or on returning to IDLE
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | PWM disabled, compare 0, waiting for start
// S_RAMP | stepping compare toward target on period boundaries
// S_ON   | compare holds at target
// S_FALL | stepping compare toward 0; disables once 0 has been reached

module pwm_fade_ctrl #(
    parameter int WIDTH  = 32,
    parameter int HOLD_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [WIDTH-1:0]  cfg_load_i,
    input  logic [WIDTH-1:0]  cfg_target_i,
    input  logic [WIDTH-1:0]  cfg_step_i,
    input  logic [HOLD_W-1:0] cfg_hold_i,
    input  logic              cmd_start_i,
    input  logic              cmd_stop_i,
`ifdef PWM_FADE_IRQ_EN
    input  logic              irq_ack_i,
    output logic              irq_o,
`endif
    output logic [WIDTH-1:0]  load_o,
    output logic [WIDTH-1:0]  compare_o,
    output logic [WIDTH-1:0]  control_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_ON   = 2'd2,
        S_FALL = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]  ONE_W  = WIDTH'(1);
    localparam logic [HOLD_W-1:0] ONE_HW = HOLD_W'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  load_q, load_d;
    logic [WIDTH-1:0]  compare_q, compare_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic [WIDTH-1:0]  step_q, step_d;
    logic [WIDTH-1:0]  pcnt_q, pcnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              en_q, en_d;
    logic              done_q, done_d;

    logic              boundary;
    logic              step_due;
    logic [HOLD_W-1:0] hold_next;
    logic [WIDTH-1:0]  goal;
    logic [WIDTH-1:0]  diff;
    logic [WIDTH-1:0]  stepped;
    logic [WIDTH-1:0]  new_step;
    logic [WIDTH-1:0]  tgt_from_idle;
    logic [WIDTH-1:0]  tgt_retarget;

    // Local copy of pwm_gen's period counter; the boundary is the last cycle of
    // a period, so a compare update lands exactly on the next period start.
    assign boundary  = en_q && (pcnt_q == load_q);
    assign step_due  = boundary && (hold_q == '0);
    assign hold_next = (hold_q == '0) ? cfg_hold_i : (hold_q - ONE_HW);

    assign new_step      = (cfg_step_i == '0) ? ONE_W : cfg_step_i;
    // A start from IDLE clamps against the load being latched in the same cycle;
    // a retarget clamps against the load already in use.
    assign tgt_from_idle = (cfg_target_i < cfg_load_i) ? cfg_target_i : cfg_load_i;
    assign tgt_retarget  = (cfg_target_i < load_q) ? cfg_target_i : load_q;

    // Saturating move toward the goal: lands exactly on the goal when within
    // one step, so it never overshoots or wraps.
    always_comb begin
        goal    = (state_q == S_FALL) ? '0 : target_q;
        diff    = '0;
        stepped = compare_q;
        if (compare_q < goal) begin
            diff    = goal - compare_q;
            stepped = (diff <= step_q) ? goal : (compare_q + step_q);
        end else begin
            diff    = compare_q - goal;
            stepped = (diff <= step_q) ? goal : (compare_q - step_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        compare_d = compare_q;
        target_d  = target_q;
        step_d    = step_q;
        hold_d    = hold_q;
        en_d      = en_q;
        done_d    = 1'b0;
        pcnt_d    = (en_q && (pcnt_q < load_q)) ? (pcnt_q + ONE_W) : '0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_start_i && !cmd_stop_i) begin
                    load_d    = cfg_load_i;
                    target_d  = tgt_from_idle;
                    step_d    = new_step;
                    compare_d = '0;
                    hold_d    = cfg_hold_i;
                    en_d      = 1'b1;
                    pcnt_d    = '0;
                    if (tgt_from_idle == '0) begin
                        state_d = S_ON;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RAMP;
                    end
                end
            end

            S_RAMP: begin
                // A command cycle consumes any coincident boundary; hold restarts.
                if (cmd_stop_i) begin
                    state_d = S_FALL;
                    hold_d  = cfg_hold_i;
                end else if (cmd_start_i) begin
                    target_d = tgt_retarget;
                    step_d   = new_step;
                    hold_d   = cfg_hold_i;
                    if (tgt_retarget == compare_q) begin
                        state_d = S_ON;
                        done_d  = 1'b1;
                    end
                end else if (boundary) begin
                    hold_d = hold_next;
                    if (step_due) begin
                        compare_d = stepped;
                        if (stepped == target_q) begin
                            state_d = S_ON;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            S_ON: begin
                if (cmd_stop_i) begin
                    state_d = S_FALL;
                    hold_d  = cfg_hold_i;
                end else if (cmd_start_i) begin
                    target_d = tgt_retarget;
                    step_d   = new_step;
                    hold_d   = cfg_hold_i;
                    if (tgt_retarget == compare_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RAMP;
                    end
                end
            end

            S_FALL: begin
                // Compare reached 0 on an earlier boundary: that final zero-duty
                // period has started, now shut the PWM off.
                if (compare_q == '0) begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                    pcnt_d  = '0;
                    done_d  = 1'b1;
                end else if (boundary) begin
                    hold_d = hold_next;
                    if (step_due) begin
                        compare_d = stepped;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            load_q    <= '0;
            compare_q <= '0;
            target_q  <= '0;
            step_q    <= '0;
            pcnt_q    <= '0;
            hold_q    <= '0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            compare_q <= compare_d;
            target_q  <= target_d;
            step_q    <= step_d;
            pcnt_q    <= pcnt_d;
            hold_q    <= hold_d;
            en_q      <= en_d;
            done_q    <= done_d;
        end
    end

`ifdef PWM_FADE_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = done_d | (irq_q & ~irq_ack_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

    assign load_o    = load_q;
    assign compare_o = compare_q;
    assign control_o = {{(WIDTH-1){1'b0}}, en_q};
    assign busy_o    = (state_q == S_RAMP) || (state_q == S_FALL);
    assign done_o    = done_q;

endmodule
